// File: rtl/target_sequencer.sv
// target_sequencer: owns game flow for switch_handler. It picks a pseudo-random
// one-hot target, holds it until a hit or until the target window expires, and
// runs the game countdown that raises game_over.
// Optional build macro TARGET_SPEEDUP_EN: each accepted hit shrinks the target
// window by STEP_MS, down to a floor of MIN_MS.
module target_sequencer #(
  parameter int unsigned N_SW      = 18,
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned TARGET_MS = 1500,
  parameter int unsigned GAME_S    = 30,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned STEP_MS   = 100,
  parameter int unsigned MIN_MS    = 300
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     target_hit,
  output logic [N_SW-1:0]          curr_target,
  output logic [$clog2(N_SW)-1:0]  target_idx,
  output logic                     game_over,
  output logic [5:0]               time_left,
  output logic                     timeout
);

  localparam int unsigned IDX_W     = $clog2(N_SW);
  localparam int unsigned TICK_DIV  = (CLK_HZ / 1000 >= 1) ? CLK_HZ / 1000 : 1;
  localparam int unsigned PRE_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [15:0] SEED      = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  // Galois mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
`ifdef TARGET_SPEEDUP_EN
  localparam int unsigned WIN_MAX   = (MIN_MS > TARGET_MS) ? MIN_MS : TARGET_MS;
`else
  localparam int unsigned WIN_MAX   = TARGET_MS;
`endif
  localparam int unsigned WIN_W     = $clog2(WIN_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_OVER
  } state_e;

  state_e            state_q;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [PRE_W-1:0]  presc_q;
  logic [9:0]        ms_q;
  logic [WIN_W-1:0]  win_q;
  logic [WIN_W-1:0]  win_lim;
  logic [N_SW-1:0]   tgt_q;
  logic [IDX_W-1:0]  idx_q;
  logic              over_q;
  logic [5:0]        tl_q;
  logic              to_q;

  logic              play;
  logic              ms_tick;
  logic              sec_tick;
  logic              game_end;
  logic              hit_acc;
  logic              expire;
  logic              enter;
  logic [IDX_W-1:0]  pick_d;
  logic [N_SW-1:0]   pick_oh_d;

  assign play     = (state_q == S_PLAY);
  assign ms_tick  = play && (presc_q == PRE_W'(TICK_DIV - 1));
  assign sec_tick = ms_tick && (ms_q == 10'd999);
  // Final second: game end takes priority over any hit or expiry in the same cycle
  assign game_end = sec_tick && (tl_q <= 6'd1);
  assign hit_acc  = play && target_hit && !game_end;
  assign expire   = play && ms_tick && (win_q >= win_lim - WIN_W'(1)) && !target_hit && !game_end;
  assign enter    = !play && start;

  // LFSR next value: one Galois step
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
  end

  // LFSR free-runs in every state so player timing feeds the sequence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

  // Next target: fold 5 LFSR bits into range, then bump off the current index
  always_comb begin
    int unsigned cand;
    cand = 32'(lfsr_q[4:0]) % N_SW;
    if (cand == 32'(idx_q)) cand = (cand == N_SW - 1) ? 32'd0 : cand + 32'd1;
    pick_d    = IDX_W'(cand);
    pick_oh_d = N_SW'(1) << pick_d;
  end

  // Millisecond prescaler and ms-of-second counter, running in PLAY only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else if (!play) begin
      presc_q <= '0;
      ms_q    <= '0;
    end else begin
      presc_q <= ms_tick ? '0 : presc_q + 1'b1;
      if (ms_tick) ms_q <= sec_tick ? '0 : ms_q + 1'b1;
    end
  end

`ifdef TARGET_SPEEDUP_EN
  logic [WIN_W-1:0] lim_q;
  assign win_lim = lim_q;

  // Window limit: restarts at TARGET_MS each game, shrinks on accepted hits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lim_q <= WIN_W'(TARGET_MS);
    end else if (enter) begin
      lim_q <= WIN_W'(TARGET_MS);
    end else if (hit_acc) begin
      if (32'(lim_q) >= MIN_MS + STEP_MS) lim_q <= lim_q - WIN_W'(STEP_MS);
      else                                lim_q <= WIN_W'(MIN_MS);
    end
  end
`else
  assign win_lim = WIN_W'(TARGET_MS);
  logic unused_cfg;
  assign unused_cfg = ^{STEP_MS, MIN_MS};
`endif

  // Game FSM with registered outputs and target window counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      idx_q   <= '0;
      over_q  <= 1'b0;
      tl_q    <= '0;
      to_q    <= 1'b0;
      win_q   <= '0;
    end else begin
      to_q <= 1'b0;
      unique case (state_q)
        S_IDLE, S_OVER: begin
          if (start) begin
            state_q <= S_PLAY;
            over_q  <= 1'b0;
            tl_q    <= 6'(GAME_S);
            idx_q   <= pick_d;
            tgt_q   <= pick_oh_d;
            win_q   <= '0;
          end
        end
        S_PLAY: begin
          if (game_end) begin
            state_q <= S_OVER;
            over_q  <= 1'b1;
            tgt_q   <= '0;
            tl_q    <= '0;
            win_q   <= '0;
          end else begin
            if (sec_tick) tl_q <= tl_q - 6'd1;
            if (hit_acc || expire) begin
              idx_q <= pick_d;
              tgt_q <= pick_oh_d;
              win_q <= '0;
            end else if (ms_tick && (win_q < win_lim)) begin
              win_q <= win_q + 1'b1;
            end
            if (expire) to_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign curr_target = tgt_q;
  assign target_idx  = idx_q;
  assign game_over   = over_q;
  assign time_left   = tl_q;
  assign timeout     = to_q;

endmodule

// File: tb/tb_target_sequencer.sv
// Self-checking bench for target_sequencer. A reference LFSR tracks the DUT
// from reset so every new target index is predicted exactly.
module tb_target_sequencer;

  localparam int unsigned N_SW       = 18;
  localparam int unsigned CLK_HZ     = 10000;
  localparam int unsigned TARGET_MS  = 5;
  localparam int unsigned GAME_S     = 2;
  localparam int unsigned STEP_MS    = 1;
  localparam int unsigned MIN_MS     = 3;
  localparam int unsigned IDX_W      = $clog2(N_SW);
  localparam logic [15:0] SEED       = 16'hACE1;
  localparam int unsigned CYC_PER_MS = CLK_HZ / 1000;
`ifdef TARGET_SPEEDUP_EN
  localparam int unsigned HIT_PERIOD = MIN_MS * CYC_PER_MS;
`else
  localparam int unsigned HIT_PERIOD = TARGET_MS * CYC_PER_MS;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              start = 1'b0;
  logic              target_hit = 1'b0;
  logic [N_SW-1:0]   curr_target;
  logic [IDX_W-1:0]  target_idx;
  logic              game_over;
  logic [5:0]        time_left;
  logic              timeout;

  int                errors = 0;
  int                checks = 0;
  logic [15:0]       m_lfsr;
  int unsigned       cur_idx = 0;
  int unsigned       exp_q[$];

  target_sequencer #(
    .N_SW      (N_SW),
    .CLK_HZ    (CLK_HZ),
    .TARGET_MS (TARGET_MS),
    .GAME_S    (GAME_S),
    .LFSR_SEED (SEED),
    .STEP_MS   (STEP_MS),
    .MIN_MS    (MIN_MS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .target_hit  (target_hit),
    .curr_target (curr_target),
    .target_idx  (target_idx),
    .game_over   (game_over),
    .time_left   (time_left),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic int unsigned exp_pick(input logic [15:0] l, input int unsigned prev);
    int unsigned c;
    c = {27'd0, l[4:0]};
    while (c >= N_SW) c = c - N_SW;
    if (c == prev) begin
      c = c + 1;
      if (c == N_SW) c = 0;
    end
    return c;
  endfunction

  function automatic logic [N_SW-1:0] onehot(input int unsigned i);
    logic [N_SW-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Reference LFSR, stepping on the same edges as the DUT
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (curr_target !== '0) begin errors++; $display("FAIL reset_target: got %h expected 0", curr_target); end
    checks++; if (target_idx !== '0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", target_idx); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL reset_over: got %b expected 0", game_over); end
    checks++; if (time_left !== 6'd0) begin errors++; $display("FAIL reset_time: got %0d expected 0", time_left); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if ({curr_target, target_idx, game_over, time_left, timeout} !== '0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected 0", i,
                 {curr_target, target_idx, game_over, time_left, timeout});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    cur_idx = 0;
  endtask

  task automatic test_start(input string tag);
    int unsigned e;
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(exp_pick(m_lfsr, cur_idx));
    @(negedge clk);
    start = 1'b0;
    e = exp_q.pop_front();
    checks++; if (time_left !== 6'(GAME_S)) begin errors++; $display("FAIL %s_time: got %0d expected %0d", tag, time_left, GAME_S); end
    checks++; if (game_over !== 1'b0) begin errors++; $display("FAIL %s_over: got %b expected 0", tag, game_over); end
    checks++; if (!$onehot(curr_target) || curr_target !== onehot(e)) begin errors++; $display("FAIL %s_target: got %h expected %h", tag, curr_target, onehot(e)); end
    checks++; if (target_idx !== IDX_W'(e)) begin errors++; $display("FAIL %s_idx: got %0d expected %0d", tag, target_idx, e); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout: got %b expected 0", tag, timeout); end
    cur_idx = e;
  endtask

  task automatic test_hits(input int n);
    int unsigned e;
    int unsigned prev;
    int unsigned gap;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < int'(gap); g++) begin
        @(negedge clk);
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL hit_gap_timeout: got %b expected 0", timeout); end
      end
      target_hit = 1'b1;
      prev = cur_idx;
      exp_q.push_back(exp_pick(m_lfsr, cur_idx));
      @(negedge clk);
      target_hit = 1'b0;
      e = exp_q.pop_front();
      checks++; if (target_idx !== IDX_W'(e)) begin errors++; $display("FAIL hit_idx #%0d: got %0d expected %0d", i, target_idx, e); end
      checks++; if (curr_target !== onehot(e)) begin errors++; $display("FAIL hit_target #%0d: got %h expected %h", i, curr_target, onehot(e)); end
      checks++; if (target_idx === IDX_W'(prev)) begin errors++; $display("FAIL hit_repeat #%0d: got %0d expected not %0d", i, target_idx, prev); end
      checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL hit_timeout #%0d: got %b expected 0", i, timeout); end
      cur_idx = e;
    end
  endtask

  task automatic test_timeouts(input int n, input int unsigned period, input string tag);
    int unsigned cyc;
    int unsigned last;
    int          seen;
    int unsigned e;
    cyc = 0; last = 0; seen = 0;
    while (seen < n && cyc < (n + 1) * period + 20) begin
      exp_q.push_back(exp_pick(m_lfsr, cur_idx));
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      if (timeout === 1'b1) begin
        checks++; if (target_idx !== IDX_W'(e) || curr_target !== onehot(e)) begin errors++; $display("FAIL %s_new_idx: got %0d expected %0d", tag, target_idx, e); end
        if (seen > 0) begin
          checks++; if (cyc - last != period) begin errors++; $display("FAIL %s_period: got %0d expected %0d", tag, cyc - last, period); end
        end
        last = cyc;
        seen++;
        cur_idx = e;
      end else begin
        checks++; if (target_idx !== IDX_W'(cur_idx)) begin errors++; $display("FAIL %s_hold: got %0d expected %0d", tag, target_idx, cur_idx); end
      end
    end
    checks++; if (seen < n) begin errors++; $display("FAIL %s_count: got %0d expected %0d", tag, seen, n); end
  endtask

  task automatic test_game_end(input bit timed, input string tag);
    int unsigned cyc;
    int          t1;
    logic [5:0]  prev_tl;
    int unsigned e;
    cyc = 0; t1 = -1;
    prev_tl = time_left;
    while (game_over !== 1'b1 && cyc < 25000) begin
      exp_q.push_back(exp_pick(m_lfsr, cur_idx));
      @(negedge clk);
      cyc++;
      e = exp_q.pop_front();
      if (game_over !== 1'b1 && timeout === 1'b1) begin
        checks++; if (target_idx !== IDX_W'(e)) begin errors++; $display("FAIL %s_to_idx: got %0d expected %0d", tag, target_idx, e); end
        cur_idx = e;
      end
      if (time_left !== prev_tl) begin
        checks++; if (time_left !== prev_tl - 6'd1) begin errors++; $display("FAIL %s_step: got %0d expected %0d", tag, time_left, prev_tl - 6'd1); end
        if (time_left === 6'd1) t1 = int'(cyc);
        prev_tl = time_left;
      end
    end
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL %s_reach_over: got %b expected 1", tag, game_over); end
    checks++; if (curr_target !== '0) begin errors++; $display("FAIL %s_target: got %h expected 0", tag, curr_target); end
    checks++; if (time_left !== 6'd0) begin errors++; $display("FAIL %s_time: got %0d expected 0", tag, time_left); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL %s_timeout: got %b expected 0", tag, timeout); end
    checks++; if (target_idx !== IDX_W'(cur_idx)) begin errors++; $display("FAIL %s_idx_held: got %0d expected %0d", tag, target_idx, cur_idx); end
    if (timed) begin
      checks++; if (t1 != 1000 * CYC_PER_MS) begin errors++; $display("FAIL %s_sec1: got %0d expected %0d", tag, t1, 1000 * CYC_PER_MS); end
      checks++; if (cyc != GAME_S * 1000 * CYC_PER_MS) begin errors++; $display("FAIL %s_len: got %0d expected %0d", tag, cyc, GAME_S * 1000 * CYC_PER_MS); end
    end
  endtask

  task automatic test_over_ignores_hit();
    @(negedge clk);
    target_hit = 1'b1;
    @(negedge clk);
    target_hit = 1'b0;
    checks++; if (game_over !== 1'b1) begin errors++; $display("FAIL over_hit_over: got %b expected 1", game_over); end
    checks++; if (curr_target !== '0) begin errors++; $display("FAIL over_hit_target: got %h expected 0", curr_target); end
    checks++; if (target_idx !== IDX_W'(cur_idx)) begin errors++; $display("FAIL over_hit_idx: got %0d expected %0d", target_idx, cur_idx); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL over_hit_timeout: got %b expected 0", timeout); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({game_over, time_left, curr_target} !== {1'b1, 6'd0, {N_SW{1'b0}}}) begin
        errors++;
        $display("FAIL over_stay cycle %0d: got over=%b time=%0d target=%h expected 1/0/0", i, game_over, time_left, curr_target);
      end
    end
  endtask

  task automatic test_reset_mid_game();
    test_start("midrst_start");
    for (int i = 0; i < 37; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({curr_target, target_idx, game_over, time_left, timeout} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got target=%h idx=%0d over=%b time=%0d to=%b expected all 0",
               curr_target, target_idx, game_over, time_left, timeout);
    end
    @(negedge clk);
    checks++; if (timeout !== 1'b0 || curr_target !== '0) begin errors++; $display("FAIL midrst_hold: got to=%b target=%h expected 0", timeout, curr_target); end
    rst_n = 1'b1;
    cur_idx = 0;
  endtask

`ifdef TARGET_SPEEDUP_EN
  task automatic test_speedup();
    test_start("sp_start");
    test_timeouts(2, TARGET_MS * CYC_PER_MS, "sp_initial");
    test_hits(1);
    test_timeouts(2, (TARGET_MS - STEP_MS) * CYC_PER_MS, "sp_hit1");
    test_hits(2);
    test_timeouts(2, MIN_MS * CYC_PER_MS, "sp_floor");
    test_hits(1);
    test_timeouts(2, MIN_MS * CYC_PER_MS, "sp_hold");
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_start("start");
    test_hits(50);
    test_timeouts(4, HIT_PERIOD, "timeout");
    test_game_end(1'b0, "end1");
    test_over_ignores_hit();
    test_start("restart");
    test_game_end(1'b1, "end2");
    test_reset_mid_game();
`ifdef TARGET_SPEEDUP_EN
    test_speedup();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
